// File: rtl/protobuf_pkg.sv
// Shared wire-type codes, error causes and decoder state encoding for the
// protobuf deserializer.
package protobuf_pkg;

    localparam logic [2:0] WT_VARINT = 3'd0;
    localparam logic [2:0] WT_I64    = 3'd1;
    localparam logic [2:0] WT_LEN    = 3'd2;
    localparam logic [2:0] WT_I32    = 3'd5;

    localparam logic [2:0] ERR_NONE       = 3'd0;
    localparam logic [2:0] ERR_VARINT_OVF = 3'd1;
    localparam logic [2:0] ERR_BAD_WTYPE  = 3'd2;
    localparam logic [2:0] ERR_FIELD_ZERO = 3'd3;
    localparam logic [2:0] ERR_LEN_OVF    = 3'd4;

    typedef enum logic [2:0] {
        S_TAG,
        S_VARINT,
        S_FIXED,
        S_LEN,
        S_EMIT,
        S_PAYLOAD,
        S_ERROR
    } state_e;

endpackage

// File: rtl/varint_accum.sv
// LSB-group-first varint accumulator shared by tag, value and length decoding.
// acc_o already includes the byte on din_i, so the caller can use it on the final byte.
module varint_accum (
    input  logic        clk,
    input  logic        srst,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic        tag_mode_i,
    input  logic [7:0]  din_i,
    output logic [63:0] acc_o,
    output logic        last_o,
    output logic        ovf_o
);

    logic [63:0] acc_q;
    logic [3:0]  cnt_q;
    logic [6:0]  shamt;

    assign shamt  = 7'(cnt_q) * 7'd7;
    assign acc_o  = acc_q | ({57'd0, din_i[6:0]} << shamt);
    assign last_o = !din_i[7];

    // Tags stop at 5 bytes; values may use a 10th byte holding only bit 63.
    assign ovf_o = tag_mode_i ? ((cnt_q == 4'd4) && din_i[7])
                              : ((cnt_q == 4'd9) && (din_i[7] || (din_i[6:1] != 6'd0)));

    always_ff @(posedge clk) begin
        if (srst || clr_i) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else if (en_i) begin
            if (last_o || ovf_o) begin
                acc_q <= '0;
                cnt_q <= '0;
            end else begin
                acc_q <= acc_o;
                cnt_q <= cnt_q + 4'd1;
            end
        end
    end

endmodule

// File: rtl/protobuf_deserializer.sv
// Streaming protobuf wire-format decoder: emits one (field, wtype, value) record per
// field and forwards length-delimited payloads. PROTOBUF_DESER_FIXED_EN enables wire types 1/5.
module protobuf_deserializer
    import protobuf_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic        clock_clk,
    input  logic        reset_reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [28:0] out_field,
    output logic [2:0]  out_wtype,
    output logic [63:0] out_value,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  pay_data,
    output logic        pay_valid,
    input  logic        pay_ready,
    output logic        pay_last,
    output logic        err,
    output logic [2:0]  err_code,
    input  logic        err_clr
);

    state_e           state_q, state_d;
    logic [28:0]      field_q, field_d;
    logic [2:0]       wtype_q, wtype_d;
    logic [63:0]      value_q, value_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [2:0]       fix_cnt_q, fix_cnt_d;
    logic [2:0]       err_code_q, err_code_d;

    logic        acc_en;
    logic        acc_tag_mode;
    logic [63:0] acc_val;
    logic        acc_last;
    logic        acc_ovf;

    varint_accum u_accum (
        .clk        (clock_clk),
        .srst       (reset_reset),
        .clr_i      (state_q == S_ERROR),
        .en_i       (acc_en),
        .tag_mode_i (acc_tag_mode),
        .din_i      (in_data),
        .acc_o      (acc_val),
        .last_o     (acc_last),
        .ovf_o      (acc_ovf)
    );

    assign out_field = field_q;
    assign out_wtype = wtype_q;
    assign out_value = value_q;
    assign err       = (state_q == S_ERROR);
    assign err_code  = err_code_q;

    always_comb begin
        state_d      = state_q;
        field_d      = field_q;
        wtype_d      = wtype_q;
        value_d      = value_q;
        rem_d        = rem_q;
        fix_cnt_d    = fix_cnt_q;
        err_code_d   = err_code_q;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        pay_data     = 8'd0;
        pay_valid    = 1'b0;
        pay_last     = 1'b0;
        acc_en       = 1'b0;
        acc_tag_mode = 1'b0;

        case (state_q)
            S_TAG: begin
                in_ready     = 1'b1;
                acc_en       = in_valid;
                acc_tag_mode = 1'b1;
                if (in_valid) begin
                    if (acc_ovf) begin
                        state_d    = S_ERROR;
                        err_code_d = ERR_VARINT_OVF;
                    end else if (acc_last) begin
                        field_d   = acc_val[31:3];
                        wtype_d   = acc_val[2:0];
                        value_d   = '0;
                        fix_cnt_d = '0;
                        if (acc_val[31:3] == 29'd0) begin
                            state_d    = S_ERROR;
                            err_code_d = ERR_FIELD_ZERO;
                        end else begin
                            case (acc_val[2:0])
                                WT_VARINT: state_d = S_VARINT;
                                WT_LEN:    state_d = S_LEN;
`ifdef PROTOBUF_DESER_FIXED_EN
                                WT_I64, WT_I32: state_d = S_FIXED;
`endif
                                default: begin
                                    state_d    = S_ERROR;
                                    err_code_d = ERR_BAD_WTYPE;
                                end
                            endcase
                        end
                    end
                end
            end

            S_VARINT, S_LEN: begin
                in_ready = 1'b1;
                acc_en   = in_valid;
                if (in_valid) begin
                    if (acc_ovf) begin
                        state_d    = S_ERROR;
                        err_code_d = ERR_VARINT_OVF;
                    end else if (acc_last) begin
                        if ((state_q == S_LEN) && ((acc_val >> LEN_W) != 64'd0)) begin
                            state_d    = S_ERROR;
                            err_code_d = ERR_LEN_OVF;
                        end else begin
                            value_d = acc_val;
                            state_d = S_EMIT;
                        end
                    end
                end
            end

`ifdef PROTOBUF_DESER_FIXED_EN
            S_FIXED: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    value_d[{fix_cnt_q, 3'b000} +: 8] = in_data;
                    fix_cnt_d = fix_cnt_q + 3'd1;
                    if (fix_cnt_q == ((wtype_q == WT_I64) ? 3'd7 : 3'd3))
                        state_d = S_EMIT;
                end
            end
`endif

            S_EMIT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if ((wtype_q == WT_LEN) && (value_q != 64'd0)) begin
                        rem_d   = value_q[LEN_W-1:0];
                        state_d = S_PAYLOAD;
                    end else begin
                        state_d = S_TAG;
                    end
                end
            end

            S_PAYLOAD: begin
                pay_data  = in_data;
                pay_valid = in_valid;
                in_ready  = pay_ready;
                pay_last  = (rem_q == LEN_W'(1));
                if (in_valid && pay_ready) begin
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1))
                        state_d = S_TAG;
                end
            end

            S_ERROR: begin
                if (err_clr) begin
                    err_code_d = ERR_NONE;
                    state_d    = S_TAG;
                end
            end

            default: state_d = S_TAG;
        endcase
    end

    always_ff @(posedge clock_clk) begin
        if (reset_reset) begin
            state_q    <= S_TAG;
            field_q    <= '0;
            wtype_q    <= '0;
            value_q    <= '0;
            rem_q      <= '0;
            fix_cnt_q  <= '0;
            err_code_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            field_q    <= field_d;
            wtype_q    <= wtype_d;
            value_q    <= value_d;
            rem_q      <= rem_d;
            fix_cnt_q  <= fix_cnt_d;
            err_code_q <= err_code_d;
        end
    end

endmodule

// File: tb/tb_protobuf_deserializer.sv
// Directed self-checking bench for protobuf_deserializer; honours PROTOBUF_DESER_FIXED_EN
// so the fixed-width vector expects a record or a bad-wire-type error accordingly.
module tb_protobuf_deserializer;

    logic        clock_clk = 1'b0;
    logic        reset_reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [28:0] out_field;
    logic [2:0]  out_wtype;
    logic [63:0] out_value;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  pay_data;
    logic        pay_valid;
    logic        pay_ready;
    logic        pay_last;
    logic        err;
    logic [2:0]  err_code;
    logic        err_clr;

    int tests = 0;
    int fails = 0;

    protobuf_deserializer #(.LEN_W(16)) dut (
        .clock_clk   (clock_clk),
        .reset_reset (reset_reset),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_field   (out_field),
        .out_wtype   (out_wtype),
        .out_value   (out_value),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .pay_data    (pay_data),
        .pay_valid   (pay_valid),
        .pay_ready   (pay_ready),
        .pay_last    (pay_last),
        .err         (err),
        .err_code    (err_code),
        .err_clr     (err_clr)
    );

    always #5 clock_clk = ~clock_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one byte and wait (bounded) until it is accepted; returns 1 time unit after that edge.
    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clock_clk);
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 20) begin
            @(negedge clock_clk);
            n++;
        end
        if (n == 20) chk("in_ready_timeout", 64'(in_ready), 64'd1);
        @(posedge clock_clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_n(input logic [63:0] bytes, input int n);
        for (int i = 0; i < n; i++) send(bytes[8*i +: 8]);
    endtask

    task automatic check_record(input string tag, input logic [28:0] f, input logic [2:0] w,
                                input logic [63:0] v);
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_field"}, 64'(out_field), 64'(f));
        chk({tag, "_wtype"}, 64'(out_wtype), 64'(w));
        chk({tag, "_value"}, out_value, v);
        $display("[TB] record %s field=%0d wtype=%0d value=%0h", tag, out_field, out_wtype, out_value);
        out_ready = 1'b1;
        @(posedge clock_clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_done"}, 64'(out_valid), 64'd0);
    endtask

    task automatic check_error(input string tag, input logic [2:0] code);
        chk({tag, "_err"}, 64'(err), 64'd1);
        chk({tag, "_code"}, 64'(err_code), 64'(code));
        chk({tag, "_inrdy"}, 64'(in_ready), 64'd0);
        chk({tag, "_oval"}, 64'(out_valid), 64'd0);
        $display("[TB] error %s code=%0d", tag, err_code);
        @(negedge clock_clk);
        err_clr = 1'b1;
        @(posedge clock_clk);
        #1;
        err_clr = 1'b0;
        chk({tag, "_clr_err"}, 64'(err), 64'd0);
        chk({tag, "_clr_code"}, 64'(err_code), 64'd0);
        chk({tag, "_clr_inrdy"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        reset_reset = 1'b1;
        in_data     = 8'd0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        pay_ready   = 1'b0;
        err_clr     = 1'b0;
        repeat (3) @(posedge clock_clk);
        #1;
        reset_reset = 1'b0;

        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_pay_valid", 64'(pay_valid), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_err_code", 64'(err_code), 64'd0);
        chk("rst_field", 64'(out_field), 64'd0);
        chk("rst_wtype", 64'(out_wtype), 64'd0);
        chk("rst_value", out_value, 64'd0);

        // 08 96 01: field 1 varint 150
        send_n(64'h01_96_08, 3);
        check_record("varint150", 29'd1, 3'd0, 64'd150);

        // 12 03 61 62 63: length-delimited record then three payload bytes
        send_n(64'h03_12, 2);
        check_record("len3", 29'd2, 3'd2, 64'd3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock_clk);
            in_data   = 8'h61 + 8'(i);
            in_valid  = 1'b1;
            pay_ready = 1'b1;
            #1;
            chk("pay_valid", 64'(pay_valid), 64'd1);
            chk("pay_data", 64'(pay_data), 64'(8'h61 + 8'(i)));
            chk("pay_last", 64'(pay_last), (i == 2) ? 64'd1 : 64'd0);
            chk("pay_in_ready", 64'(in_ready), 64'd1);
            $display("[TB] payload byte %0d data=%0h last=%0d", i, pay_data, pay_last);
            @(posedge clock_clk);
            #1;
            in_valid = 1'b0;
        end
        pay_ready = 1'b0;
        #1;
        chk("pay_back_to_tag", 64'(in_ready), 64'd1);

        // 12 00: zero-length payload goes straight back to tag decoding
        send_n(64'h00_12, 2);
        check_record("len0", 29'd2, 3'd2, 64'd0);
        chk("len0_tag", 64'(in_ready), 64'd1);

        // 0D 78 56 34 12: fixed32
`ifdef PROTOBUF_DESER_FIXED_EN
        send_n(64'h12_34_56_78_0D, 5);
        check_record("fixed32", 29'd1, 3'd5, 64'h12345678);
`else
        send(8'h0D);
        check_error("fixed32_off", 3'd2);
`endif

        // 08 then ten FF bytes: value varint overflow, then recovery with 08 01
        send(8'h08);
        for (int i = 0; i < 10; i++) send(8'hFF);
        @(negedge clock_clk);
        chk("ovf_sticky", 64'(err), 64'd1);
        check_error("varint_ovf", 3'd1);
        send_n(64'h01_08, 2);
        check_record("after_clr", 29'd1, 3'd0, 64'd1);

        // Boundary errors: 5-byte tag with continuation, field zero, bad wtype, length 65536
        send_n(64'h80_80_80_80_88, 5);
        check_error("tag_ovf", 3'd1);
        send(8'h00);
        check_error("field_zero", 3'd3);
        send(8'h0B);
        check_error("wtype3", 3'd2);
        send_n(64'h04_80_80_12, 4);
        check_error("len_ovf", 3'd4);

        // Backpressure: record held for 5 cycles while in_valid is offered
        send_n(64'h01_96_08, 3);
        @(negedge clock_clk);
        in_data  = 8'hFF;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("hold_in_ready", 64'(in_ready), 64'd0);
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_value", out_value, 64'd150);
            chk("hold_field", 64'(out_field), 64'd1);
            @(negedge clock_clk);
        end
        in_valid = 1'b0;
        check_record("held", 29'd1, 3'd0, 64'd150);
        send_n(64'h00_10, 2);
        check_record("after_hold", 29'd2, 3'd0, 64'd0);

        // Reset mid-record drops the partial varint
        send_n(64'h96_08, 2);
        @(negedge clock_clk);
        reset_reset = 1'b1;
        @(negedge clock_clk);
        reset_reset = 1'b0;
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        send_n(64'h01_08, 2);
        check_record("midrst", 29'd1, 3'd0, 64'd1);
        repeat (3) begin
            @(negedge clock_clk);
            chk("midrst_single", 64'(out_valid), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/protobuf_deserializer.md
PROTOBUF_DESERIALIZER -- requirements
Module: protobuf_deserializer

Interface
REQ-001 SHALL have parameter LEN_W, default 16: width of the length-delimited payload length; lengths >= 2^LEN_W are errors.
REQ-002 SHALL have port clock_clk  in  1  sole clock; all logic rising-edge.
REQ-003 SHALL have port reset_reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port in_data  in  8  serialized protobuf byte stream.
REQ-005 SHALL have ports in_valid  in  1 and in_ready  out  1: input byte handshake, byte accepted when both high.
REQ-006 SHALL have port out_field  out  29  field number of the current record.
REQ-007 SHALL have port out_wtype  out  3  wire type of the current record.
REQ-008 SHALL have port out_value  out  64  decoded value (varint/fixed) or payload length (type 2).
REQ-009 SHALL have ports out_valid  out  1 and out_ready  in  1: record handshake.
REQ-010 SHALL have ports pay_data  out  8, pay_valid  out  1, pay_ready  in  1, pay_last  out  1: length-delimited payload byte stream.
REQ-011 SHALL have ports err  out  1 and err_code  out  3: sticky error flag and cause (1 varint overflow, 2 bad wire type, 3 field zero, 4 length overflow).
REQ-012 SHALL have port err_clr  in  1  single-cycle pulse that clears the error.

Function
REQ-013 SHALL implement states TAG, VARINT, FIXED, LEN, EMIT, PAYLOAD and ERROR.
REQ-014 SHALL decode varints LSB-group-first: 7 bits per byte; bit 7 = continuation; byte k lands at bit 7k.
REQ-015 SHALL limit the tag varint to 5 bytes; field = tag[31:3], wtype = tag[2:0]; a 5th byte with continuation set -> error 1.
REQ-016 SHALL treat field 0 as error 3 and wtype 3, 4, 6 or 7 as error 2, detected on the final tag byte.
REQ-017 SHALL route TAG to VARINT (wtype 0), LEN (wtype 2) or FIXED (wtype 1/5).
REQ-018 SHALL limit value varints to 10 bytes; a 10th byte with continuation set or value > 1 -> error 1.
REQ-019 SHALL assemble FIXED values little-endian, 8 bytes for wtype 1 and 4 for wtype 5, with out_value[63:32] zero for wtype 5.
REQ-020 SHALL raise error 4 from LEN on a length varint >= 2^LEN_W.
REQ-021 SHALL assert out_valid the cycle after the final byte of a value or length is accepted (latency 1) and hold it in EMIT until out_ready.
REQ-022 SHALL hold in_ready low in EMIT, and SHALL keep out_* stable while out_valid && !out_ready.
REQ-023 SHALL leave EMIT to PAYLOAD for wtype 2 with length > 0, otherwise to TAG.
REQ-024 SHALL pass PAYLOAD through combinationally: pay_data = in_data, pay_valid = in_valid, in_ready = pay_ready.
REQ-025 SHALL assert pay_last on the final payload byte and then return to TAG.
REQ-026 SHALL hold in_ready high in TAG, VARINT, FIXED and LEN.
REQ-027 SHALL, on entering ERROR: hold err = 1, latch err_code, force in_ready = 0, out_valid = 0, pay_valid = 0, and discard any partial record.
REQ-028 SHALL, on err_clr in ERROR: return to TAG next cycle with err = 0 and err_code = 0; err_clr outside ERROR has no effect.

Reset
REQ-029 SHALL, on reset_reset, enter TAG and drive out_valid = 0, pay_valid = 0, err = 0, err_code = 0 and out_field/out_wtype/out_value = 0.
REQ-030 SHALL clear all accumulators and counters on reset; reset mid-record drops the partial record.
REQ-031 SHALL drive in_ready = 1 in the first cycle after reset is deasserted.

Configuration
REQ-032 SHALL decode wire types 1 and 5 via FIXED when PROTOBUF_DESER_FIXED_EN is defined.
REQ-033 SHALL, when PROTOBUF_DESER_FIXED_EN is undefined, omit FIXED and treat wtype 1 and 5 as error 2.

Structure
REQ-034 SHALL place wire-type constants (WT_VARINT=0, WT_I64=1, WT_LEN=2, WT_I32=5), err_code constants and the state enum in shared package protobuf_pkg.
REQ-035 SHALL use one sub-module, varint_accum (shift/accumulate, byte count, overflow flag), shared by TAG, VARINT and LEN.

Verification
REQ-036 SHALL cover: in 08 96 01 -> out_field=1, out_wtype=0, out_value=150, one record.
REQ-037 SHALL cover: in 12 03 61 62 63 -> record field 2, wtype 2, value 3; then pay_data 61,62,63 with pay_last on 63.
REQ-038 SHALL cover: in 0D 78 56 34 12 -> field 1, wtype 5, value 0x12345678 with FIXED_EN; err_code=2 without it.
REQ-039 SHALL cover: in 08 then 10 bytes FF -> err=1, err_code=1; then err_clr, in 08 01 -> value 1.
REQ-040 SHALL cover: in 08 96 01 with out_ready low 5 cycles -> in_ready=0 and outputs stable; then in 10 00 -> field 2, value 0.
REQ-041 SHALL cover: in 08 96, reset pulse, in 08 01 -> exactly one record, value 1.
